mem_io_responder: RTL and testbench

Responder end of the CPU's byte-wide memory bus: accepts the per-cycle address/write/data stream driven by the `cpu` top and returns read data one cycle later. It contains the 128 KB byte RAM and the memory-mapped I/O block at 0x30000–0x30007: console input, a buffered console output, a free-running cycle counter and a program-stop flag. It sits beside `cpu` in the system top, wired straight to its `mem_a`/`mem_wr`/`mem_dout`/`mem_din` pins.

---
 rtl/mem_io_responder.sv | 153 +++++++++++++++
 tb/tb_mem_io_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// Responder side of the CPU byte bus: 2^ADDR_WIDTH-byte RAM plus the I/O block
// at 0x30000-0x30007 (console in, buffered console out, cycle counter, stop flag).
module mem_io_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int OUT_DEPTH  = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        en,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  input  logic        io_in_valid,
  input  logic [7:0]  io_in_data,
  output logic        io_in_pop,
  output logic        io_out_valid,
  output logic [7:0]  io_out_data,
  input  logic        io_out_ready,
  output logic        prog_stop,
  output logic        out_ovf
);

  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(OUT_DEPTH);

  // ---------------------------------------------------------------- decode
  logic        acc, rd, wr;
  logic        is_ram, is_io;
  logic [2:0]  off;
  logic        rd_in, rd_cnt, wr_out, wr_stop;
  logic        new_in, new_cnt;
  logic        prev_in_rd, prev_cnt_rd;
  logic [ADDR_WIDTH-1:0] ra;
  logic        unused;

  assign acc     = en && !rst_in;
  assign rd      = acc && !mem_wr;
  assign wr      = acc && mem_wr;
  assign is_ram  = !mem_a[17];
  assign is_io   = (mem_a[17:16] == 2'b11);
  assign off     = mem_a[2:0];
  assign ra      = mem_a[ADDR_WIDTH-1:0];
  assign unused  = ^mem_a[31:18];

  assign rd_in   = rd && is_io && (off == 3'd0);
  assign rd_cnt  = rd && is_io && (off == 3'd4);
  assign wr_out  = wr && is_io && (off == 3'd0);
  assign wr_stop = wr && is_io && (off == 3'd4);

  // "New" means the previous enabled cycle was not the same read.
  assign new_in  = rd_in && !prev_in_rd;
  assign new_cnt = rd_cnt && !prev_cnt_rd;

  assign io_in_pop = new_in && io_in_valid;

  // ---------------------------------------------------------------- RAM
  logic [7:0] ram [2**ADDR_WIDTH];
  logic [7:0] ram_q;

  always_ff @(posedge clk_in) begin
    if (wr && is_ram) ram[ra] <= mem_dout;
    if (rd && is_ram) ram_q <= ram[ra];
  end

  // ---------------------------------------------------------------- I/O regs
  logic [31:0] cnt, snap;
  logic [7:0]  in_byte, io_rdata, io_q;
  logic        src_ram;

  always_comb begin
    io_rdata = 8'h00;
    if (is_io) begin
      unique case (off)
        3'd0:    io_rdata = new_in ? (io_in_valid ? io_in_data : 8'h00) : in_byte;
        3'd4:    io_rdata = new_cnt ? cnt[7:0] : snap[7:0];
        3'd5:    io_rdata = snap[15:8];
        3'd6:    io_rdata = snap[23:16];
        3'd7:    io_rdata = snap[31:24];
        default: io_rdata = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt         <= '0;
      snap        <= '0;
      in_byte     <= '0;
      io_q        <= '0;
      src_ram     <= 1'b0;
      prev_in_rd  <= 1'b0;
      prev_cnt_rd <= 1'b0;
    end else begin
      cnt <= cnt + 32'd1;
      if (acc) begin
        prev_in_rd  <= rd_in;
        prev_cnt_rd <= rd_cnt;
      end
      if (rd) begin
        src_ram <= is_ram;
        if (!is_ram) io_q <= io_rdata;
      end
      if (new_in)  in_byte <= io_in_valid ? io_in_data : 8'h00;
      if (new_cnt) snap    <= cnt;
    end
  end

  // RAM output and I/O output are both registered; src_ram picks the last read's source.
  assign mem_din = src_ram ? ram_q : io_q;

  // ---------------------------------------------------------------- output FIFO
  logic [7:0]  fifo [OUT_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [PW:0] count;
  logic        push_req, push, pop, full;
  logic [7:0]  push_byte;

  // A stop write is the only path for 0x00 into the FIFO.
  assign push_req  = ((wr_out && (mem_dout != 8'h00)) || wr_stop) && !prog_stop;
  assign push_byte = wr_stop ? 8'h00 : mem_dout;
  assign full      = (count == FULL_CNT);
  assign pop       = io_out_valid && io_out_ready;
  assign push      = push_req && (!full || pop);

  always_ff @(posedge clk_in) begin
    if (push) fifo[wptr] <= push_byte;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      prog_stop <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (wr_stop)          prog_stop <= 1'b1;
      if (push_req && !push) out_ovf  <= 1'b1;
    end
  end

  assign io_out_valid = (count != '0);
  assign io_out_data  = io_out_valid ? fifo[rptr] : 8'h00;

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: directed scenarios plus random traffic, all
// outputs checked each cycle against a queue/array model of the bus semantics.
module tb_mem_io_responder;
  localparam int AW = 17;
  localparam int D  = 8;

  logic        clk = 1'b0;
  logic        rst, en, wr, in_valid, pop_o, ready, out_valid, stop, ovf;
  logic [31:0] a;
  logic [7:0]  dout, din, in_data, out_data;

  mem_io_responder #(.ADDR_WIDTH(AW), .OUT_DEPTH(D)) dut (
    .clk_in(clk), .rst_in(rst), .en(en), .mem_a(a), .mem_wr(wr),
    .mem_dout(dout), .mem_din(din), .io_in_valid(in_valid),
    .io_in_data(in_data), .io_in_pop(pop_o), .io_out_valid(out_valid),
    .io_out_data(out_data), .io_out_ready(ready), .prog_stop(stop),
    .out_ovf(ovf));

  always #5 clk = ~clk;

  // model state
  logic [7:0]  m_ram [0:(1<<AW)-1];
  logic [7:0]  m_q [$];
  logic [7:0]  m_din, m_in_byte;
  logic [31:0] m_cnt, m_snap;
  logic        m_stop, m_ovf, m_prev_in, m_prev_cnt;
  int          total = 0, bad = 0, pops = 0;
  logic [31:0] ram_set [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // One bus cycle: inputs are already applied; check the combinational pop,
  // advance the model on the edge, then check every registered output.
  task automatic step();
    logic io, isram, rin, rc, popq, pushf;
    logic [2:0] off;
    logic [7:0] b;
    io    = (a[17:16] == 2'b11);
    isram = !a[17];
    off   = a[2:0];
    rin   = en && !wr && io && off == 3'd0;
    rc    = en && !wr && io && off == 3'd4;
    #3;
    chk("in_pop", pop_o, !rst && rin && !m_prev_in && in_valid);
    if (pop_o) pops++;
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_stop = 0; m_ovf = 0; m_cnt = 0; m_snap = 0;
      m_prev_in = 0; m_prev_cnt = 0; m_din = 0;
    end else begin
      popq  = (m_q.size() > 0) && ready;
      pushf = 0;
      b     = 8'h00;
      if (en) begin
        if (!wr) begin
          if (isram) m_din = m_ram[a[16:0]];
          else if (!io) m_din = 8'h00;
          else case (off)
            3'd0: begin
              if (!m_prev_in) m_in_byte = in_valid ? in_data : 8'h00;
              m_din = m_in_byte;
            end
            3'd4: begin
              if (!m_prev_cnt) m_snap = m_cnt;
              m_din = m_snap[7:0];
            end
            3'd5: m_din = m_snap[15:8];
            3'd6: m_din = m_snap[23:16];
            3'd7: m_din = m_snap[31:24];
            default: m_din = 8'h00;
          endcase
        end else if (isram) begin
          m_ram[a[16:0]] = dout;
        end else if (io && !m_stop && ((off == 3'd0 && dout != 8'h00) || off == 3'd4)) begin
          b = (off == 3'd4) ? 8'h00 : dout;
          if (off == 3'd4) m_stop = 1;
          if (m_q.size() < D || popq) pushf = 1;
          else m_ovf = 1;
        end
        m_prev_in  = rin;
        m_prev_cnt = rc;
      end
      if (popq)  void'(m_q.pop_front());
      if (pushf) m_q.push_back(b);
      m_cnt++;
    end
    #1;
    chk("mem_din", din, m_din);
    chk("out_valid", out_valid, m_q.size() > 0);
    chk("out_data", out_data, (m_q.size() > 0) ? m_q[0] : 8'h00);
    chk("prog_stop", stop, m_stop);
    chk("out_ovf", ovf, m_ovf);
  endtask

  task automatic idle();
    rst = 0; en = 0; wr = 0; step();
  endtask
  task automatic do_rst();
    rst = 1; en = 0; wr = 0; step(); rst = 0;
  endtask
  task automatic bus_rd(input logic [31:0] ad);
    rst = 0; en = 1; wr = 0; a = ad; step();
  endtask
  task automatic bus_wr(input logic [31:0] ad, input logic [7:0] d);
    rst = 0; en = 1; wr = 1; a = ad; dout = d; step();
  endtask

  initial begin
    rst = 1; en = 0; wr = 0; a = 0; dout = 0; in_valid = 0; in_data = 0; ready = 0;
    do_rst(); do_rst();
    chk("rst_din", din, 8'h00);
    chk("rst_valid", out_valid, 1'b0);

    // RAM
    bus_wr(32'h00100, 8'hA5);
    bus_wr(32'h1FFFF, 8'h3C);
    bus_rd(32'h00100); chk("ram_lo", din, 8'hA5);
    bus_rd(32'h1FFFF); chk("ram_hi", din, 8'h3C);
    bus_rd(32'h20010); chk("unmapped", din, 8'h00);

    // console input
    in_valid = 1; in_data = 8'h41; pops = 0;
    bus_rd(32'h30000); chk("in_first", din, 8'h41);
    bus_rd(32'h30000); chk("in_repeat", din, 8'h41);
    chk("in_one_pop", pops, 1);
    bus_rd(32'h00100);
    in_valid = 0; pops = 0;
    bus_rd(32'h30000); chk("in_empty", din, 8'h00);
    chk("in_no_pop", pops, 0);

    // console output, zero byte filtered
    ready = 0;
    bus_wr(32'h30000, 8'h48); bus_wr(32'h30000, 8'h00); bus_wr(32'h30000, 8'h69);
    chk("out_head", out_data, 8'h48);
    ready = 1;
    idle(); chk("out_second", out_data, 8'h69);
    idle(); chk("out_drained", out_valid, 1'b0);
    ready = 0;
    for (int i = 0; i <= D; i++) bus_wr(32'h30000, 8'(i + 1));
    chk("ovf_set", ovf, 1'b1);
    ready = 1;
    for (int i = 0; i < D; i++) begin
      chk("ovf_order", out_data, 8'(i + 1));
      idle();
    end
    chk("ovf_empty", out_valid, 1'b0);
    ready = 0;

    // cycle counter snapshot
    do_rst();
    while (m_cnt != 32'h1234) idle();
    bus_rd(32'h30004); chk("cnt_b0", din, 8'h34);
    bus_rd(32'h30005); chk("cnt_b1", din, 8'h12);
    bus_rd(32'h30006); chk("cnt_b2", din, 8'h00);
    bus_rd(32'h30007); chk("cnt_b3", din, 8'h00);

    // stop
    bus_wr(32'h30004, 8'h77);
    chk("stop_set", stop, 1'b1);
    chk("stop_zero_valid", out_valid, 1'b1);
    chk("stop_zero_data", out_data, 8'h00);
    ready = 1; idle();
    bus_wr(32'h30000, 8'h55);
    idle(); chk("stop_drop", out_valid, 1'b0);
    ready = 0;

    // reset mid-operation
    do_rst();
    bus_wr(32'h30000, 8'h01); bus_wr(32'h30000, 8'h02); bus_wr(32'h30000, 8'h03);
    while (m_cnt != 32'd500) idle();
    do_rst();
    chk("mrst_valid", out_valid, 1'b0);
    chk("mrst_stop", stop, 1'b0);
    chk("mrst_ovf", ovf, 1'b0);
    idle();
    bus_rd(32'h30004); chk("mrst_cnt", din, 8'h01);
    bus_rd(32'h00100); chk("ram_kept", din, 8'hA5);

    // random traffic over a known RAM set, I/O and unmapped space
    do_rst();
    for (int i = 0; i < 16; i++) begin
      ram_set[i] = 32'($urandom_range(0, 32'h1FFFF));
      bus_wr(ram_set[i], 8'($urandom));
    end
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      en       = ($urandom_range(0, 3) != 0);
      wr       = $urandom_range(0, 2) == 0;
      case ($urandom_range(0, 2))
        0:       a = ram_set[$urandom_range(0, 15)];
        1:       a = 32'h30000 + 32'($urandom_range(0, 7));
        default: a = 32'h20000 + 32'($urandom_range(0, 255));
      endcase
      dout     = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      in_valid = $urandom_range(0, 1) == 1;
      in_data  = 8'($urandom);
      ready    = en && ($urandom_range(0, 2) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
